player_sprite_drawer: RTL

PLAYER_SPRITE_DRAWER -- requirements
Module: player_sprite_drawer

---
 rtl/player_sprite_drawer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/player_sprite_drawer.sv
// Redraws the player sprite into the frame buffer on each frame tick: erases the
// previously drawn rectangle, draws the new one, then pulses done.
module player_sprite_drawer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int PLAYER_WIDTH  = 32,
    parameter int PLAYER_HEIGHT = 32
) (
    input  logic       CLOCK_50,
    input  logic       global_reset_n,
    input  logic [9:0] in_x,
    input  logic [8:0] in_y,
    input  logic       start,
    input  logic       fb_ready,
    output logic       fb_write,
    output logic [9:0] fb_x,
    output logic [8:0] fb_y,
    output logic       fb_color,
    output logic       busy,
    output logic       done
);
    localparam int CW = (PLAYER_WIDTH  > 2) ? $clog2(PLAYER_WIDTH)  : 1;
    localparam int RW = (PLAYER_HEIGHT > 2) ? $clog2(PLAYER_HEIGHT) : 1;
    localparam logic signed [10:0] HALF_W = 11'(PLAYER_WIDTH / 2);
    localparam logic signed [10:0] HALF_H = 11'(PLAYER_HEIGHT / 2);
    localparam logic signed [10:0] SW_S   = 11'(SCREEN_WIDTH);
    localparam logic signed [10:0] SH_S   = 11'(SCREEN_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(PLAYER_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(PLAYER_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

    state_t            state;
    logic [9:0]        new_x, drawn_x;
    logic [8:0]        new_y, drawn_y;
    logic              drawn_valid;
    logic [CW-1:0]     col_cnt;
    logic [RW-1:0]     row_cnt;
    logic              all_issued;

    logic [9:0]        rect_x;
    logic [8:0]        rect_y;
    logic signed [10:0] px, py;
    logic              in_bounds;
    logic              slot_free;

    // Erase works on the old rectangle, draw on the new one.
    always_comb begin
        rect_x    = (state == ERASE) ? drawn_x : new_x;
        rect_y    = (state == ERASE) ? drawn_y : new_y;
        px        = $signed({1'b0, rect_x}) - HALF_W + $signed(11'(col_cnt));
        py        = $signed({2'b00, rect_y}) - HALF_H + $signed(11'(row_cnt));
        in_bounds = (px >= 0) && (px < SW_S) && (py >= 0) && (py < SH_S);
        slot_free = !(fb_write && !fb_ready);
    end

    always_ff @(posedge CLOCK_50 or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state       <= IDLE;
            fb_write    <= 1'b0;
            fb_x        <= '0;
            fb_y        <= '0;
            fb_color    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            new_x       <= '0;
            new_y       <= '0;
            drawn_x     <= '0;
            drawn_y     <= '0;
            drawn_valid <= 1'b0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            all_issued  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fb_write <= 1'b0;
                    done     <= 1'b0;
                    busy     <= start;
                    if (start) begin
                        new_x      <= in_x;
                        new_y      <= in_y;
                        col_cnt    <= '0;
                        row_cnt    <= '0;
                        all_issued <= 1'b0;
                        if (drawn_valid && in_x == drawn_x && in_y == drawn_y)
                            state <= FINISH;
                        else if (drawn_valid)
                            state <= ERASE;
                        else
                            state <= DRAW;
                    end
                end
                ERASE, DRAW: begin
                    if (slot_free) begin
                        if (!all_issued) begin
                            // Off-screen pixels still take a cycle but present no write.
                            fb_write <= in_bounds;
                            fb_x     <= px[9:0];
                            fb_y     <= py[8:0];
                            fb_color <= (state == DRAW);
                            if (col_cnt == LAST_COL) begin
                                col_cnt <= '0;
                                if (row_cnt == LAST_ROW) begin
                                    row_cnt    <= '0;
                                    all_issued <= 1'b1;
                                end else begin
                                    row_cnt <= row_cnt + 1'b1;
                                end
                            end else begin
                                col_cnt <= col_cnt + 1'b1;
                            end
                        end else begin
                            fb_write   <= 1'b0;
                            all_issued <= 1'b0;
                            if (state == ERASE) begin
                                state <= DRAW;
                            end else begin
                                drawn_x     <= new_x;
                                drawn_y     <= new_y;
                                drawn_valid <= 1'b1;
                                state       <= FINISH;
                            end
                        end
                    end
                end
                FINISH: begin
                    fb_write <= 1'b0;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
